// File: rtl/nasti_ddrx_cmd_sched_if.sv
// Request and DFI command/data-enable signals of the DDRx command scheduler.
// Master is the request/PHY side; slave is the scheduler.
interface nasti_ddrx_cmd_sched_if #(
  parameter int ROW_W  = 14,
  parameter int BANK_W = 3,
  parameter int COL_W  = 10
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [BANK_W-1:0] req_bank;
  logic [ROW_W-1:0]  req_row;
  logic [COL_W-1:0]  req_col;
  logic              dfi_init_start;
  logic              dfi_init_complete;
  logic              dfi_cke;
  logic              dfi_cs_n;
  logic              dfi_ras_n;
  logic              dfi_cas_n;
  logic              dfi_we_n;
  logic [ROW_W-1:0]  dfi_address;
  logic [BANK_W-1:0] dfi_bank;
  logic              dfi_wrdata_en;
  logic              dfi_rddata_en;
  logic              ref_busy;

  modport master (
    output req_valid, req_write, req_bank, req_row, req_col, dfi_init_complete,
    input  req_ready, dfi_init_start, dfi_cke, dfi_cs_n, dfi_ras_n, dfi_cas_n,
           dfi_we_n, dfi_address, dfi_bank, dfi_wrdata_en, dfi_rddata_en, ref_busy
  );

  modport slave (
    input  req_valid, req_write, req_bank, req_row, req_col, dfi_init_complete,
    output req_ready, dfi_init_start, dfi_cke, dfi_cs_n, dfi_ras_n, dfi_cas_n,
           dfi_we_n, dfi_address, dfi_bank, dfi_wrdata_en, dfi_rddata_en, ref_busy
  );
endinterface

// File: rtl/nasti_ddrx_cmd_sched.sv
// Single-transaction DDRx command scheduler: ACT -> RD/WR -> PRE with periodic
// refresh. Next values are computed combinationally, every output is a register.
module nasti_ddrx_cmd_sched #(
  parameter int ROW_W   = 14,
  parameter int BANK_W  = 3,
  parameter int COL_W   = 10,
  parameter int T_RCD   = 4,
  parameter int T_RAS   = 10,
  parameter int T_RTP   = 3,
  parameter int T_WTP   = 8,
  parameter int T_RP    = 4,
  parameter int T_RFC   = 20,
  parameter int T_REFI  = 200,
  parameter int T_WREN  = 2,
  parameter int T_RDEN  = 5,
  parameter int T_BURST = 4
) (
  input  logic                  core_clk,
  input  logic                  core_rst,
  nasti_ddrx_cmd_sched_if.slave bus
);
  localparam logic [3:0] ST_INIT     = 4'd0;
  localparam logic [3:0] ST_IDLE     = 4'd1;
  localparam logic [3:0] ST_ACT      = 4'd2;
  localparam logic [3:0] ST_WAIT_RCD = 4'd3;
  localparam logic [3:0] ST_COL      = 4'd4;
  localparam logic [3:0] ST_WAIT_PRE = 4'd5;
  localparam logic [3:0] ST_PRE      = 4'd6;
  localparam logic [3:0] ST_WAIT_RP  = 4'd7;
  localparam logic [3:0] ST_REF      = 4'd8;
  localparam logic [3:0] ST_WAIT_RFC = 4'd9;

  localparam logic [3:0] CMD_DESEL = 4'b1111;
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_RD    = 4'b0101;
  localparam logic [3:0] CMD_WR    = 4'b0100;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_REF   = 4'b0001;

  localparam int CNT_W = $clog2(T_RCD + T_RP + T_RFC + 1);
  localparam int TP_W  = $clog2(T_RAS + T_RTP + T_WTP + 1);
  localparam int DAT_W = $clog2(T_WREN + T_RDEN + T_BURST + 1);
  localparam int REF_W = $clog2(T_REFI + 1);

  logic [3:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [TP_W-1:0]   r_rasCnt;
  logic [TP_W-1:0]   r_tpCnt;
  logic [DAT_W-1:0]  r_wrCnt;
  logic [DAT_W-1:0]  r_rdCnt;
  logic [REF_W-1:0]  r_refCnt;
  logic              r_refPend;
  logic              r_write;
  logic [BANK_W-1:0] r_bank;
  logic [COL_W-1:0]  r_col;
  logic [3:0]        r_cmd;
  logic [ROW_W-1:0]  r_addr;
  logic [BANK_W-1:0] r_dfiBank;
  logic              r_cke;
  logic              r_initStart;
  logic              r_ready;
  logic              r_wrEn;
  logic              r_rdEn;
  logic              r_refBusy;

  logic [3:0]        w_stateNxt;
  logic [CNT_W-1:0]  w_cntNxt;
  logic [3:0]        w_cmdNxt;
  logic [ROW_W-1:0]  w_addrNxt;
  logic [BANK_W-1:0] w_bankNxt;
  logic [TP_W-1:0]   w_rasCntNxt;
  logic [TP_W-1:0]   w_tpCntNxt;
  logic [DAT_W-1:0]  w_wrCntNxt;
  logic [DAT_W-1:0]  w_rdCntNxt;
  logic [REF_W-1:0]  w_refCntNxt;
  logic              w_refPendNxt;
  logic              w_issueAct;
  logic              w_issueCol;
  logic              w_issueRef;
  logic              w_expire;
  logic              w_preOk;
  logic [ROW_W-1:0]  w_colAddr;

  // Column addresses never reach A10 because COL_W <= 10.
  assign w_colAddr  = {{(ROW_W - COL_W){1'b0}}, r_col};
  assign w_issueRef = (r_state == ST_IDLE) && r_refPend;
  assign w_issueAct = (r_state == ST_IDLE) && !r_refPend && bus.req_valid;
  assign w_issueCol = (r_state == ST_WAIT_RCD) && (r_cnt == '0);
  assign w_preOk    = (r_rasCnt == '0) && (r_tpCnt == '0);
  assign w_expire   = (r_state != ST_INIT) && (r_refCnt == '0);

  always_comb begin
    w_stateNxt = r_state;
    w_cntNxt   = (r_cnt != '0) ? r_cnt - 1'b1 : r_cnt;
    w_cmdNxt   = CMD_NOP;
    w_addrNxt  = r_addr;
    w_bankNxt  = r_dfiBank;
    case (r_state)
      ST_INIT: begin
        w_cmdNxt = CMD_DESEL;
        if (bus.dfi_init_complete) begin
          w_stateNxt = ST_IDLE;
          w_cmdNxt   = CMD_NOP;
        end
      end
      ST_IDLE: begin
        if (r_refPend) begin
          w_stateNxt = ST_REF;
          w_cmdNxt   = CMD_REF;
          w_addrNxt  = '0;
          w_bankNxt  = '0;
        end else if (bus.req_valid) begin
          w_stateNxt = ST_ACT;
          w_cmdNxt   = CMD_ACT;
          w_addrNxt  = bus.req_row;
          w_bankNxt  = bus.req_bank;
        end
      end
      ST_ACT: begin
        w_stateNxt = ST_WAIT_RCD;
        w_cntNxt   = CNT_W'(T_RCD - 2);
      end
      ST_WAIT_RCD: begin
        if (r_cnt == '0) begin
          w_stateNxt = ST_COL;
          w_cmdNxt   = r_write ? CMD_WR : CMD_RD;
          w_addrNxt  = w_colAddr;
          w_bankNxt  = r_bank;
        end
      end
      ST_COL, ST_WAIT_PRE: begin
        w_stateNxt = ST_WAIT_PRE;
        if (w_preOk) begin
          w_stateNxt = ST_PRE;
          w_cmdNxt   = CMD_PRE;
          w_addrNxt  = '0;
          w_bankNxt  = r_bank;
        end
      end
      ST_PRE: begin
        w_stateNxt = ST_WAIT_RP;
        w_cntNxt   = CNT_W'(T_RP - 2);
      end
      ST_WAIT_RP:  if (r_cnt == '0) w_stateNxt = ST_IDLE;
      ST_REF: begin
        w_stateNxt = ST_WAIT_RFC;
        w_cntNxt   = CNT_W'(T_RFC - 2);
      end
      ST_WAIT_RFC: if (r_cnt == '0) w_stateNxt = ST_IDLE;
      default:     w_stateNxt = ST_INIT;
    endcase
  end

  // A counter value of zero in cycle x means the PRE may appear at x+1.
  assign w_rasCntNxt = w_issueAct ? TP_W'(T_RAS - 1) :
                       (r_rasCnt != '0) ? r_rasCnt - 1'b1 : r_rasCnt;
  assign w_tpCntNxt  = w_issueCol ? (r_write ? TP_W'(T_WTP - 1) : TP_W'(T_RTP - 1)) :
                       (r_tpCnt != '0) ? r_tpCnt - 1'b1 : r_tpCnt;
  assign w_wrCntNxt  = (w_issueCol && r_write) ? DAT_W'(T_WREN + T_BURST) :
                       (r_wrCnt != '0) ? r_wrCnt - 1'b1 : r_wrCnt;
  assign w_rdCntNxt  = (w_issueCol && !r_write) ? DAT_W'(T_RDEN + T_BURST) :
                       (r_rdCnt != '0) ? r_rdCnt - 1'b1 : r_rdCnt;
  assign w_refCntNxt = (r_state == ST_INIT) ?
                       ((w_stateNxt == ST_IDLE) ? REF_W'(T_REFI - 1) : '0) :
                       (r_refCnt == '0) ? REF_W'(T_REFI - 1) : r_refCnt - 1'b1;
  assign w_refPendNxt = w_expire || (r_refPend && !w_issueRef);

  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      r_state     <= ST_INIT;
      r_cnt       <= '0;
      r_rasCnt    <= '0;
      r_tpCnt     <= '0;
      r_wrCnt     <= '0;
      r_rdCnt     <= '0;
      r_refCnt    <= '0;
      r_refPend   <= 1'b0;
      r_write     <= 1'b0;
      r_bank      <= '0;
      r_col       <= '0;
      r_cmd       <= CMD_DESEL;
      r_addr      <= '0;
      r_dfiBank   <= '0;
      r_cke       <= 1'b0;
      r_initStart <= 1'b0;
      r_ready     <= 1'b0;
      r_wrEn      <= 1'b0;
      r_rdEn      <= 1'b0;
      r_refBusy   <= 1'b0;
    end else begin
      r_state     <= w_stateNxt;
      r_cnt       <= w_cntNxt;
      r_rasCnt    <= w_rasCntNxt;
      r_tpCnt     <= w_tpCntNxt;
      r_wrCnt     <= w_wrCntNxt;
      r_rdCnt     <= w_rdCntNxt;
      r_refCnt    <= w_refCntNxt;
      r_refPend   <= w_refPendNxt;
      r_cmd       <= w_cmdNxt;
      r_addr      <= w_addrNxt;
      r_dfiBank   <= w_bankNxt;
      r_cke       <= (w_stateNxt != ST_INIT);
      r_initStart <= (w_stateNxt == ST_INIT);
      r_ready     <= (w_stateNxt == ST_IDLE) && !w_refPendNxt;
      r_refBusy   <= w_refPendNxt || (w_stateNxt == ST_REF) || (w_stateNxt == ST_WAIT_RFC);
      r_wrEn      <= (w_wrCntNxt != '0) && (w_wrCntNxt <= DAT_W'(T_BURST));
      r_rdEn      <= (w_rdCntNxt != '0) && (w_rdCntNxt <= DAT_W'(T_BURST));
      if (w_issueAct) begin
        r_write <= bus.req_write;
        r_bank  <= bus.req_bank;
        r_col   <= bus.req_col;
      end
    end
  end

  assign bus.req_ready      = r_ready;
  assign bus.dfi_init_start = r_initStart;
  assign bus.dfi_cke        = r_cke;
  assign {bus.dfi_cs_n, bus.dfi_ras_n, bus.dfi_cas_n, bus.dfi_we_n} = r_cmd;
  assign bus.dfi_address    = r_addr;
  assign bus.dfi_bank       = r_dfiBank;
  assign bus.dfi_wrdata_en  = r_wrEn;
  assign bus.dfi_rddata_en  = r_rdEn;
  assign bus.ref_busy       = r_refBusy;
endmodule

// File: doc/nasti_ddrx_cmd_sched.md
NASTI_DDRX_CMD_SCHED -- requirements
Module: nasti_ddrx_cmd_sched

Parameters
REQ-001 SHALL have parameters, one per line (name, default, meaning):
- ROW_W, 14, row address width; also dfi_address width.
- BANK_W, 3, bank address width.
- COL_W, 10, column address width; COL_W < ROW_W and COL_W <= 10.
- T_RCD, 4, cycles from ACT to RD/WR.
- T_RAS, 10, cycles from ACT to PRE, minimum.
- T_RTP, 3, cycles from RD to PRE, minimum.
- T_WTP, 8, cycles from WR to PRE, minimum.
- T_RP, 4, cycles from PRE to next ACT/REF.
- T_RFC, 20, cycles from REF to next ACT/REF.
- T_REFI, 200, refresh interval in cycles.
- T_WREN, 2, cycles from WR to first dfi_wrdata_en cycle; must be >= 1.
- T_RDEN, 5, cycles from RD to first dfi_rddata_en cycle; must be >= 1.
- T_BURST, 4, enable pulse length in cycles.

Interface
REQ-002 SHALL have ports, one per line (name, direction, width, meaning), clock and reset first:
- core_clk, in, 1, sole clock; all logic on its rising edge.
- core_rst, in, 1, asynchronous, active-high reset.
- req_valid, in, 1, request valid.
- req_ready, out, 1, request accepted when valid && ready.
- req_write, in, 1, 1 = write, 0 = read.
- req_bank, in, BANK_W, target bank.
- req_row, in, ROW_W, target row.
- req_col, in, COL_W, target column.
- dfi_init_start, out, 1, request PHY initialisation.
- dfi_init_complete, in, 1, PHY initialisation done.
- dfi_cke, out, 1, clock enable.
- dfi_cs_n, out, 1, chip select.
- dfi_ras_n, out, 1, command strobe.
- dfi_cas_n, out, 1, command strobe.
- dfi_we_n, out, 1, command strobe.
- dfi_address, out, ROW_W, row address, or column address with A10 = 0.
- dfi_bank, out, BANK_W, command bank.
- dfi_wrdata_en, out, 1, write data window.
- dfi_rddata_en, out, 1, read data window.
- ref_busy, out, 1, high while a refresh is pending or in progress.

Function
REQ-003 All outputs SHALL be registered.
REQ-004 Command encodings ({cs_n, ras_n, cas_n, we_n}) SHALL be:
- DESELECT 1111, NOP 0111, ACT 0011, RD 0101, WR 0100, PRE 0010, REF 0001.
REQ-005 Each command other than NOP/DESELECT SHALL be driven for exactly one cycle.
- Idle cycles SHALL drive DESELECT before init completes and NOP after.
REQ-006 States SHALL be:
- INIT, IDLE, ACT, WAIT_RCD, COL, WAIT_PRE, PRE, WAIT_RP, REF, WAIT_RFC.
REQ-007 INIT behaviour:
- dfi_init_start = 1.
- On dfi_init_complete = 1 (sampled): dfi_init_start <= 0, dfi_cke <= 1, go to IDLE.
- dfi_cke SHALL then stay 1 until reset.
REQ-008 req_ready SHALL be 1 only in IDLE with no refresh pending.
- Handshake at cycle a: capture write/bank/row/col.
- ACT on outputs at a+1 with dfi_address = row and dfi_bank = bank.
REQ-009 Column command:
- RD or WR SHALL appear exactly T_RCD cycles after ACT.
- dfi_address = zero-extended col, A10 = 0; same bank.
REQ-010 PRE SHALL appear at max(ACT + T_RAS, COL + T_RTP) for reads, or max(ACT + T_RAS, COL + T_WTP) for writes.
- PRE uses the same bank, A10 = 0.
REQ-011 After PRE the block SHALL return to IDLE so that req_ready = 1 at PRE + T_RP.
REQ-012 Write data window: dfi_wrdata_en = 1 for cycles WR + T_WREN .. WR + T_WREN + T_BURST - 1.
REQ-013 Read data window: dfi_rddata_en = 1 for cycles RD + T_RDEN .. RD + T_RDEN + T_BURST - 1.
- The windows SHALL complete even after the state machine has returned to IDLE or moved to refresh.
REQ-014 Refresh counter:
- Down-counter loads T_REFI-1 on entry to IDLE from INIT.
- Decrements every cycle; at 0 it sets ref_pending and reloads.
- An expiry while already pending SHALL leave ref_pending = 1 (no queuing).
REQ-015 Refresh issue:
- In IDLE with ref_pending, issue REF next cycle and clear ref_pending.
- req_ready = 0 until REF + T_RFC.
- Refresh SHALL NOT preempt an in-flight transaction; it waits for IDLE.
REQ-016 Priority: if req_valid and ref_pending coincide in IDLE, refresh SHALL win; the request waits with req_ready = 0.
REQ-017 ref_busy = ref_pending | (state in {REF, WAIT_RFC}).

Reset
REQ-018 On core_rst = 1, asynchronously:
- state = INIT.
- dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n = 1.
- dfi_cke, dfi_init_start, req_ready, dfi_wrdata_en, dfi_rddata_en, ref_busy = 0.
- dfi_address, dfi_bank = 0.
- All counters and pending flags cleared.
REQ-019 dfi_init_start SHALL rise in the first cycle after reset deassertion.
REQ-020 Reset mid-transaction SHALL abandon the transaction with no further command or data enable.

Verification
REQ-021 Init: hold dfi_init_complete = 0 for 50 cycles, then 1 -> DESELECT throughout; init_start drops and cke rises one cycle after; req_ready = 1 next.
REQ-022 Read bank 2, row 0x123, col 0x40 accepted at a -> ACT a+1, RD a+5 with addr 0x040, PRE a+11, rddata_en a+10..a+13, req_ready a+15.
REQ-023 Write bank 5, row 0x3FFF, col 0x3FF at a -> ACT a+1, WR a+5, wrdata_en a+7..a+10, PRE a+13, req_ready a+17.
REQ-024 Refresh expiry mid-read -> REF one cycle after return to IDLE; req_ready = 0 for T_RFC cycles; pending request then served.
REQ-025 req_valid held continuously across T_REFI expiry at IDLE -> REF issued before the ACT.
REQ-026 core_rst pulsed between ACT and RD -> outputs at reset values immediately; no RD/PRE follows; INIT re-entered.
